// File: rtl/mem_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank among NUM_REQ requesters, one access per cycle.
// Optional MANNIX_ARB_ADDR_CHECK_EN: requests whose addr[18:15] != BANK_ID are consumed, dropped and flagged.
module mem_sram_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter logic [3:0]  BANK_ID = 4'd0,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_mask_en,
  input  logic [NUM_REQ*DATA_W-1:0]   req_mask,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic [15:0]                 conflict_cnt,
  output logic                        err_valid,
  output logic [NUM_REQ-1:0]          err_req,
  output logic                        sram_cs,
  output logic                        sram_read,
  output logic                        sram_write,
  output logic                        sram_mask_enable,
  output logic [3:0]                  sram_id,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_data_in,
  output logic [DATA_W-1:0]           sram_mask,
  input  logic [DATA_W-1:0]           sram_data_out
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_rd_valid;
  logic [15:0]        r_conflict_cnt;

  logic [ADDR_W-1:0]  w_addr_a [NUM_REQ];
  logic [DATA_W-1:0]  w_data_a [NUM_REQ];
  logic [DATA_W-1:0]  w_mask_a [NUM_REQ];

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_wr;
  logic               w_bank_ok;
  logic               w_fwd;

  // Unpack the flat request buses into per-requester lanes
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_data_a[g] = req_data[g*DATA_W +: DATA_W];
    assign w_mask_a[g] = req_mask[g*DATA_W +: DATA_W];
  end

  // First valid requester at or after the round-robin pointer wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_grant   = w_found ? (NUM_REQ'(1) << w_win) : '0;
  assign w_addr    = w_addr_a[w_win];
  assign w_wr      = req_write[w_win];

`ifdef MANNIX_ARB_ADDR_CHECK_EN
  assign w_bank_ok = (w_addr[ADDR_W-1 -: 4] == BANK_ID);
`else
  assign w_bank_ok = 1'b1;
`endif

  assign w_fwd = w_found & w_bank_ok;

  // Bank pins driven straight from the winner; everything held at zero when nothing is forwarded
  always_comb begin
    req_ready        = w_grant;
    sram_cs          = w_fwd;
    sram_read        = w_fwd & ~w_wr;
    sram_write       = w_fwd & w_wr;
    sram_mask_enable = w_fwd & w_wr & req_mask_en[w_win];
    sram_addr        = w_fwd ? w_addr : '0;
    sram_data_in     = w_fwd ? w_data_a[w_win] : '0;
    sram_mask        = w_fwd ? w_mask_a[w_win] : '0;
  end

  assign sram_id      = BANK_ID;
  assign rd_data      = sram_data_out;
  assign rd_valid     = r_rd_valid;
  assign conflict_cnt = r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_rd_valid     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_found) begin
        r_rr_ptr <= PTR_W'((int'(w_win) + 1) % NUM_REQ);
      end
      r_rd_valid <= (w_fwd & ~w_wr) ? w_grant : '0;
      if (($countones(req_valid) > 1) && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

`ifdef MANNIX_ARB_ADDR_CHECK_EN
  logic               r_err_valid;
  logic [NUM_REQ-1:0] r_err_req;

  // One-cycle flag for a request that was consumed but not sent to the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_req   <= '0;
    end else begin
      r_err_valid <= w_found & ~w_bank_ok;
      r_err_req   <= (w_found & ~w_bank_ok) ? w_grant : '0;
    end
  end

  assign err_valid = r_err_valid;
  assign err_req   = r_err_req;
`else
  assign err_valid = 1'b0;
  assign err_req   = '0;
`endif

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Bench for mem_sram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_sram_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 19;
  localparam int unsigned DW   = 256;
  localparam logic [3:0]  BANK = 4'd0;
`ifdef MANNIX_ARB_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_write = '0, req_mask_en = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0, req_mask = '0;
  logic [N-1:0]    req_ready, rd_valid, err_req;
  logic [DW-1:0]   rd_data, sram_data_in, sram_mask;
  logic [DW-1:0]   sram_data_out = '0;
  logic [15:0]     conflict_cnt;
  logic            err_valid, sram_cs, sram_read, sram_write, sram_mask_enable;
  logic [3:0]      sram_id;
  logic [AW-1:0]   sram_addr;

  int n_chk = 0;
  int n_fail = 0;

  mem_sram_arbiter #(.NUM_REQ(N), .BANK_ID(BANK), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_mask_en(req_mask_en), .req_mask(req_mask), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .conflict_cnt(conflict_cnt),
    .err_valid(err_valid), .err_req(err_req),
    .sram_cs(sram_cs), .sram_read(sram_read), .sram_write(sram_write),
    .sram_mask_enable(sram_mask_enable), .sram_id(sram_id), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_mask(sram_mask), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rline();
    logic [DW-1:0] r;
    for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Bank model: write-first single-port array with registered read data
  logic [DW-1:0] smem [int];
  always @(posedge clk) begin
    int key;
    logic [DW-1:0] old;
    key = int'(sram_addr[14:5]);
    old = smem.exists(key) ? smem[key] : '0;
    if (sram_cs && sram_write)
      smem[key] = sram_mask_enable ? ((old & ~sram_mask) | (sram_data_in & sram_mask)) : sram_data_in;
    if (sram_cs && sram_read) sram_data_out <= old;
  end

  // Transaction-level reference: who wins, what the bank sees, what comes back next cycle
  int            m_ptr = 0;
  int            m_cnt = 0;
  logic [N-1:0]  m_rdv = '0;
  logic [DW-1:0] m_rdd = '0;
  logic          m_errv = 1'b0;
  logic [N-1:0]  m_errq = '0;
  logic [DW-1:0] rmem [int];
  int            waits [N];

  always @(negedge clk) begin
    int win, idx, key;
    logic [N-1:0] g;
    logic [AW-1:0] a;
    logic [DW-1:0] d, mk, old;
    logic w, me, fwd;
    if (!rst_n) begin
      m_ptr = 0; m_cnt = 0; m_rdv = '0; m_errv = 1'b0; m_errq = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    g = '0; a = '0; d = '0; mk = '0; w = 1'b0; me = 1'b0;
    if (win >= 0) begin
      g = N'(1) << win;
      a = req_addr[win*AW +: AW];
      d = req_data[win*DW +: DW];
      mk = req_mask[win*DW +: DW];
      w = req_write[win];
      me = req_mask_en[win];
    end
    fwd = (win >= 0) && (!CHK_EN || a[18:15] == BANK);

    chk("req_ready", DW'(req_ready), DW'(g));
    chk("sram_cs", DW'(sram_cs), DW'(fwd));
    chk("sram_read", DW'(sram_read), DW'(fwd && !w));
    chk("sram_write", DW'(sram_write), DW'(fwd && w));
    chk("sram_mask_enable", DW'(sram_mask_enable), DW'(fwd && w && me));
    chk("sram_addr", DW'(sram_addr), fwd ? DW'(a) : '0);
    chk("sram_data_in", sram_data_in, fwd ? d : '0);
    chk("sram_mask", sram_mask, fwd ? mk : '0);
    chk("sram_id", DW'(sram_id), DW'(BANK));
    chk("rd_valid", DW'(rd_valid), DW'(m_rdv));
    if (m_rdv != '0) chk("rd_data", rd_data, m_rdd);
    chk("conflict_cnt", DW'(conflict_cnt), DW'(m_cnt));
    chk("err_valid", DW'(err_valid), DW'(m_errv));
    chk("err_req", DW'(err_req), DW'(m_errq));

    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          chk("starvation_bound", DW'(waits[i] <= N - 1), DW'(1));
          waits[i] = 0;
        end else if (req_valid[i]) waits[i]++;
        else waits[i] = 0;
      end
      key = int'(a[14:5]);
      old = rmem.exists(key) ? rmem[key] : '0;
      if (win >= 0) m_ptr = (win + 1) % N;
      if (fwd && w) rmem[key] = me ? ((old & ~mk) | (d & mk)) : d;
      m_rdv = (fwd && !w) ? g : '0;
      m_rdd = old;
      m_errv = (win >= 0) && !fwd;
      m_errq = m_errv ? g : '0;
      if ($countones(req_valid) > 1 && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic me, input logic [DW-1:0] mk);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_mask_en[i] = me;
    req_mask[i*DW +: DW] = mk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] lA, lB, lC, expd;
    logic [N-1:0] granted;
    logic [3:0] bank;
    lA = rline(); lB = rline(); lC = rline();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_valid", DW'(rd_valid), '0);
    chk("reset_conflict", DW'(conflict_cnt), '0);
    chk("reset_err_valid", DW'(err_valid), '0);
    chk("reset_ready", DW'(req_ready), '0);
    step();
    rst_n = 1'b1;

    // single requester write then read back
    setreq(0, 1'b1, 19'h00020, lA, 1'b0, '0);
    @(negedge clk); chk("t1_wr_ready", DW'(req_ready), DW'(4'b0001));
    step();
    setreq(0, 1'b0, 19'h00020, '0, 1'b0, '0);
    @(negedge clk); chk("t1_rd_ready", DW'(req_ready), DW'(4'b0001));
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_rd_valid", DW'(rd_valid), DW'(4'b0001));
    chk("t1_rd_data", rd_data, lA);
    step();

    // all four reading for 8 cycles: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) setreq(i, 1'b0, 19'h00000, '0, 1'b0, '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); chk("t2_rotation", DW'(req_ready), DW'(4'b0001 << (c % 4)));
      step();
    end
    req_valid = '0;
    @(negedge clk); chk("t2_conflict_cnt", DW'(conflict_cnt), DW'(16'd8));
    step();

    // masked write over a known line
    setreq(2, 1'b1, 19'h00000, lB, 1'b0, '0);
    step();
    setreq(2, 1'b1, 19'h00000, {DW{1'b1}}, 1'b1, DW'(8'hFF));
    step();
    setreq(2, 1'b0, 19'h00000, '0, 1'b0, '0);
    step();
    req_valid = '0;
    expd = lB;
    expd[7:0] = 8'hFF;
    @(negedge clk);
    chk("t3_rd_valid", DW'(rd_valid), DW'(4'b0100));
    chk("t3_rd_data", rd_data, expd);
    step();

    // write by req1 followed immediately by read of the same line by req2
    setreq(1, 1'b1, 19'h00040, lC, 1'b0, '0);
    step();
    req_valid = '0;
    setreq(2, 1'b0, 19'h00040, '0, 1'b0, '0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t4_rd_valid", DW'(rd_valid), DW'(4'b0100));
    chk("t4_rd_data", rd_data, lC);
    step();

    // reset lands while a read response is in flight
    setreq(0, 1'b0, 19'h00020, '0, 1'b0, '0);
    step();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("t5_rd_valid", DW'(rd_valid), '0);
    chk("t5_conflict_cnt", DW'(conflict_cnt), '0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) setreq(i, 1'b0, 19'h00000, '0, 1'b0, '0);
    @(negedge clk); chk("t5_ptr_zero", DW'(req_ready), DW'(4'b0001));
    step();
    req_valid = '0;
    step();

    // request aimed at another bank
    setreq(3, 1'b0, 19'h18000, '0, 1'b0, '0);
    @(negedge clk);
    chk("t6_ready", DW'(req_ready), DW'(4'b1000));
    chk("t6_cs", DW'(sram_cs), DW'(!CHK_EN));
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t6_err_valid", DW'(err_valid), DW'(CHK_EN));
    chk("t6_err_req", DW'(err_req), CHK_EN ? DW'(4'b1000) : '0);
    chk("t6_rd_valid", DW'(rd_valid), CHK_EN ? '0 : DW'(4'b1000));
    step();

    // randomized traffic; payload held until accepted
    repeat (3000) begin
      @(negedge clk);
      granted = req_valid & req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || granted[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            bank = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : BANK;
            setreq(i, 1'($urandom_range(0, 1)),
                   {bank, 10'($urandom_range(0, 15)), 5'($urandom_range(0, 31))},
                   rline(), 1'($urandom_range(0, 1)), rline());
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    req_valid = '0;
    step();
    step();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
